// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I memory stage: byte/half/word loads and stores
// with optional wait states.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0,
  parameter     INIT_FILE   = "dmem.hex"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwriteM,
  input  logic        memtoregM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        errM
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic          req;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          complete;
  logic          stall_raw;
  logic          err_cond;
  logic          wr_en;
  logic [3:0]    be;
  logic [31:0]   wsh;
  logic [31:0]   word;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic [31:0]   fmt;
  logic          unused_addr_bits;

  assign req  = memwriteM | memtoregM;
  assign idx  = aluoutM[AW+1:2];
  assign lane = aluoutM[1:0];
  assign unused_addr_bits = ^aluoutM[31:AW+2];

  generate
    if (WAIT_CYCLES == 0) begin : g_nowait
      assign complete  = req;
      assign stall_raw = 1'b0;
    end else begin : g_wait
      typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

      state_t     state;
      logic [3:0] cnt;

      // The IDLE cycle is the first stall cycle, so WAIT covers the remaining N-1.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          case (state)
            IDLE: if (req) begin
              cnt   <= 4'(WAIT_CYCLES - 1);
              state <= (WAIT_CYCLES == 1) ? DONE : WAIT;
            end
            WAIT: begin
              cnt <= cnt - 4'd1;
              if (cnt == 4'd1) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end

      assign stall_raw = ((state == IDLE) && req) || (state == WAIT);
      assign complete  = (state == DONE) && req;
    end
  endgenerate

  always_comb begin
    err_cond = 1'b0;
    case (funct3M)
      3'b000, 3'b100: err_cond = memwriteM & funct3M[2];
      3'b001, 3'b101: err_cond = aluoutM[0] | (memwriteM & funct3M[2]);
      3'b010:         err_cond = (aluoutM[1:0] != 2'b00);
      default:        err_cond = 1'b1;
    endcase
    if (memwriteM && memtoregM) err_cond = 1'b1;
  end

  always_comb begin
    be  = 4'b1111;
    wsh = writedataM;
    case (funct3M[1:0])
      2'b00: begin
        be  = 4'b0001 << lane;
        wsh = {4{writedataM[7:0]}};
      end
      2'b01: begin
        be  = lane[1] ? 4'b1100 : 4'b0011;
        wsh = {2{writedataM[15:0]}};
      end
      default: begin
        be  = 4'b1111;
        wsh = writedataM;
      end
    endcase
  end

  assign wr_en = complete & memwriteM & ~err_cond & ~reset;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
      end
    end
  end

  always_comb begin
    word = mem[idx];
    bsel = word[{lane, 3'b000} +: 8];
    hsel = lane[1] ? word[31:16] : word[15:0];
    case (funct3M)
      3'b000:  fmt = {{24{bsel[7]}}, bsel};
      3'b100:  fmt = {24'h0, bsel};
      3'b001:  fmt = {{16{hsel[15]}}, hsel};
      3'b101:  fmt = {16'h0, hsel};
      3'b010:  fmt = word;
      default: fmt = '0;
    endcase
  end

  assign stallM    = stall_raw & ~reset;
  assign errM      = complete & err_cond & ~reset;
  assign readdataM = (complete & memtoregM & ~err_cond & ~reset) ? fmt : '0;

endmodule
